capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Capture sequencer for the acquisition buffer.
- Arms the per-channel trigger_logic instances, fills the pre-trigger region of a circular sample RAM and qualifies the combined channel triggers.
- After a trigger, writes the post-trigger region and raises capture_done until the host clears it.
- Sits between the host command interface, the trigger logic and the sample RAM write port.

Parameters:
- NUM_CH, 5, number of channel trigger inputs
- ADDR_W, 9, sample RAM address width; DEPTH = 2**ADDR_W

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle capture start command
- abort  in  1  one-cycle abort command
- clr_done  in  1  one-cycle clear of capture_done
- trig_pos  in  ADDR_W  pre-trigger sample count, 0..DEPTH-1; latched on accepted start
- ch_en  in  NUM_CH  channel trigger enables; sampled every cycle
- ch_trig  in  NUM_CH  CHxTrig outputs of the trigger_logic instances
- smpl_en  in  1  decimated sample strobe; one sample per high cycle
- armed  out  1  drives the trigger_logic armed input
- we  out  1  RAM write enable
- waddr  out  ADDR_W  RAM write address
- trig_addr  out  ADDR_W  address of the first post-trigger sample
- triggered  out  1  trigger accepted, capture not yet cleared
- busy  out  1  high in any state except IDLE
- capture_done  out  1  post-trigger region complete

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - All counters are 0.
- States: IDLE, PRETRIG, ARMED, POSTTRIG, DONE.
- Registered outputs:
  - armed = (state==ARMED)
  - busy = (state!=IDLE)
  - capture_done = (state==DONE)
- Combinational outputs:
  - we = smpl_en & state in {PRETRIG, ARMED, POSTTRIG}
  - waddr increments by 1 on each we and wraps DEPTH-1 -> 0.
- IDLE + start:
  - Latch trig_pos.
  - waddr = 0, pre_cnt = 0, triggered = 0.
  - Next state is PRETRIG, or ARMED if trig_pos == 0.
- PRETRIG:
  - Each we increments pre_cnt.
  - A write with pre_cnt == trig_pos-1 moves the block to ARMED next cycle.
  - ch_trig is ignored.
- ARMED:
  - Writes continue circularly.
  - Combined trigger: trig_in = (|ch_en) & (&(ch_trig | ~ch_en)).
  - ch_en == 0 never triggers.
  - On trig_in the next state is POSTTRIG, triggered is set, and post_cnt (ADDR_W+1 bits) is set to 0.
  - trig_addr is captured as waddr+1 if we is high that cycle, else waddr.
  - A sample written in the trigger cycle counts as pre-trigger.
- POSTTRIG:
  - Each we increments post_cnt.
  - The write with post_cnt == DEPTH-trig_pos-1 is the last one; the next state is DONE.
  - ch_trig is ignored.
  - Total post-trigger writes = DEPTH - trig_pos.
- DONE:
  - we = 0.
  - waddr holds the oldest-sample address.
  - clr_done -> IDLE and clears triggered.
  - trig_addr and waddr hold until the next start.
- Command priority:
  - start in any non-IDLE state is ignored.
  - clr_done outside DONE is ignored.
  - start together with clr_done in DONE: clr_done wins and start is ignored.
  - abort from any non-IDLE state -> IDLE next cycle. we is low from that cycle; triggered clears and capture_done is not set. abort has priority over every other event.
- Counters and trig_pos are static while not counting; trig_pos changes after start have no effect.
- rst at any time returns to IDLE next edge with all outputs at their reset values.

Test Plan:
1. ADDR_W=4, trig_pos=4, smpl_en=1, ch_en=5'b00001:
   - start -> PRETRIG writes addr 0..3, then armed=1.
   - Assert ch_trig[0] in the cycle waddr=9 -> that write at 9, trig_addr=10.
   - 12 post writes at 10..15, 0..5, then capture_done=1 with waddr=6.
   - clr_done -> busy=0, triggered=0.
2. trig_pos=0: start -> armed=1 on the next cycle with no writes before it. Immediate ch_trig -> trig_addr=0, 16 post writes, capture_done=1.
3. smpl_en high every 3rd cycle, trig_pos=2, ch_trig held 1 throughout PRETRIG:
   - armed rises only after 2 strobes.
   - The trigger is accepted on the first ARMED cycle.
   - we pulses only with smpl_en.
4. ch_en=5'b00110:
   - ch_trig=5'b00010 -> no trigger.
   - ch_trig=5'b00110 -> trigger.
   - With ch_en=0 and ch_trig=all 1s, the block stays ARMED for 100 cycles.
5. abort mid-POSTTRIG:
   - Next cycle busy=0, we=0, capture_done never asserts.
   - A following start captures normally from waddr=0.
6. Command handling:
   - start during ARMED is ignored; waddr continues and trig_pos is not relatched.
   - In DONE, start with clr_done -> IDLE, no new capture.
   - rst asserted mid-ARMED -> all outputs 0 next cycle.

Source files
------------

// File: rtl/capture_ctrl.sv
// Capture sequencer for the acquisition buffer: fills the pre-trigger region of a
// circular sample RAM, qualifies the channel triggers, then writes the post-trigger region.
module capture_ctrl #(
  parameter int NUM_CH = 5,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              clr_done,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic              smpl_en,
  output logic              armed,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              triggered,
  output logic              busy,
  output logic              capture_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRETRIG,
    S_ARMED,
    S_POSTTRIG,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] trig_pos_q, trig_pos_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
  logic              triggered_q, triggered_d;
  logic              armed_q, busy_q, done_q;
  logic              trig_in;
  logic              writing;

  // Disabled channels are don't-care; an all-disabled mask must never fire.
  assign trig_in = (|ch_en) & (&(ch_trig | ~ch_en));
  assign writing = smpl_en & ((state_q == S_PRETRIG) || (state_q == S_ARMED) ||
                              (state_q == S_POSTTRIG));

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    state_d     = state_q;
    waddr_d     = waddr_q;
    pre_cnt_d   = pre_cnt_q;
    trig_pos_d  = trig_pos_q;
    trig_addr_d = trig_addr_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;

    if (writing) waddr_d = waddr_q + ADDR_W'(1);

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            trig_pos_d  = trig_pos;
            waddr_d     = '0;
            pre_cnt_d   = '0;
            triggered_d = 1'b0;
            state_d     = (trig_pos == '0) ? S_ARMED : S_PRETRIG;
          end
        end
        S_PRETRIG: begin
          if (writing) begin
            pre_cnt_d = pre_cnt_q + ADDR_W'(1);
            if (pre_cnt_q == trig_pos_q - ADDR_W'(1)) state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_in) begin
            state_d     = S_POSTTRIG;
            triggered_d = 1'b1;
            post_cnt_d  = '0;
            // A sample written in the trigger cycle still belongs to the pre-trigger region.
            trig_addr_d = writing ? waddr_q + ADDR_W'(1) : waddr_q;
          end
        end
        S_POSTTRIG: begin
          if (writing) begin
            post_cnt_d = post_cnt_q + (ADDR_W+1)'(1);
            // DEPTH-1-trig_pos is the bitwise complement of trig_pos in ADDR_W bits.
            if (post_cnt_q == {1'b0, ~trig_pos_q}) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (clr_done) begin
            state_d     = S_IDLE;
            triggered_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: synchronous active-high reset; all state uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      pre_cnt_q   <= '0;
      trig_pos_q  <= '0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      pre_cnt_q   <= pre_cnt_d;
      trig_pos_q  <= trig_pos_d;
      trig_addr_q <= trig_addr_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      armed_q     <= (state_d == S_ARMED);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign armed        = armed_q;
  assign busy         = busy_q;
  assign capture_done = done_q;
  assign triggered    = triggered_q;
  assign trig_addr    = trig_addr_q;
  assign waddr        = waddr_q;
  assign we           = writing;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl (ADDR_W=4): expected RAM write addresses are
// queued as each capture is set up and popped by a monitor on every observed write.
module tb_capture_ctrl;

  localparam int NUM_CH = 5;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort, clr_done, smpl_en;
  logic [ADDR_W-1:0] trig_pos;
  logic [NUM_CH-1:0] ch_en, ch_trig;
  logic              armed, we, triggered, busy, capture_done;
  logic [ADDR_W-1:0] waddr, trig_addr;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  capture_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .clr_done(clr_done),
    .trig_pos(trig_pos), .ch_en(ch_en), .ch_trig(ch_trig), .smpl_en(smpl_en),
    .armed(armed), .we(we), .waddr(waddr), .trig_addr(trig_addr),
    .triggered(triggered), .busy(busy), .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back((first + k) % DEPTH);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (capture_done) break;
      step();
    end
    check(tag, capture_done, 1);
  endtask

  // Scoreboard: every RAM write must match the next queued address and coincide with a strobe.
  always @(negedge clk) begin
    if (we) begin
      check("we_strobe", smpl_en, 1);
      if (exp_q.size() == 0) check("we_unexpected", {31'd0, we}, 0);
      else check("waddr", waddr, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1; start = 0; abort = 0; clr_done = 0; smpl_en = 0;
    trig_pos = '0; ch_en = '0; ch_trig = '0;
    step(); step();
    check("rst_armed", armed, 0);
    check("rst_busy", busy, 0);
    check("rst_done", capture_done, 0);
    check("rst_trig", triggered, 0);
    check("rst_waddr", waddr, 0);
    check("rst_taddr", trig_addr, 0);
    rst = 1'b0;

    // Basic capture: 4 pre-trigger samples, trigger while writing address 9.
    push_range(0, 10);
    push_range(10, 12);
    trig_pos = 4; smpl_en = 1; ch_en = 5'b00001; start = 1;
    step(); start = 0;
    check("t1_busy", busy, 1);
    check("t1_pre_armed", armed, 0);
    repeat (4) step();
    check("t1_armed", armed, 1);
    check("t1_armed_waddr", waddr, 4);
    repeat (5) step();
    check("t1_waddr9", waddr, 9);
    ch_trig = 5'b00001;
    step(); ch_trig = '0;
    check("t1_triggered", triggered, 1);
    check("t1_trig_addr", trig_addr, 10);
    check("t1_disarmed", armed, 0);
    wait_done("t1_done", 40);
    check("t1_done_waddr", waddr, 6);
    check("t1_sb_empty", exp_q.size(), 0);
    clr_done = 1;
    step(); clr_done = 0;
    check("t1_clr_busy", busy, 0);
    check("t1_clr_trig", triggered, 0);
    check("t1_clr_done", capture_done, 0);

    // trig_pos=0: armed immediately, trigger without a write in that cycle.
    push_range(0, 16);
    trig_pos = 0; smpl_en = 0; start = 1;
    step(); start = 0;
    check("t2_armed", armed, 1);
    check("t2_waddr", waddr, 0);
    ch_trig = 5'b00001;
    step(); ch_trig = '0; smpl_en = 1;
    check("t2_triggered", triggered, 1);
    check("t2_trig_addr", trig_addr, 0);
    wait_done("t2_done", 40);
    check("t2_done_waddr", waddr, 0);
    check("t2_sb_empty", exp_q.size(), 0);
    clr_done = 1;
    step(); clr_done = 0;

    // Sparse strobes, trigger held through PRETRIG.
    push_range(0, 2);
    push_range(2, 14);
    trig_pos = 2; smpl_en = 0; ch_trig = 5'b00001; start = 1;
    step(); start = 0;
    for (int k = 1; k <= 7; k++) begin
      smpl_en = (k % 3 == 0);
      check("t3_armed", armed, (k == 7));
      step();
    end
    ch_trig = '0;
    check("t3_triggered", triggered, 1);
    check("t3_trig_addr", trig_addr, 2);
    for (int k = 8; k < 120; k++) begin
      if (capture_done) break;
      smpl_en = (k % 3 == 0);
      step();
    end
    check("t3_done", capture_done, 1);
    check("t3_done_waddr", waddr, 0);
    check("t3_sb_empty", exp_q.size(), 0);
    clr_done = 1; smpl_en = 0;
    step(); clr_done = 0;

    // Channel masking.
    ch_en = 5'b00110; trig_pos = 0; start = 1;
    step(); start = 0;
    check("t4_armed", armed, 1);
    ch_trig = 5'b00010;
    repeat (3) step();
    check("t4_partial_notrig", triggered, 0);
    ch_en = '0; ch_trig = '1; cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (armed && !triggered) cnt++;
    end
    check("t4_noen_stays_armed", cnt, 100);
    ch_en = 5'b00110; ch_trig = 5'b00110;
    step(); ch_trig = '0;
    check("t4_triggered", triggered, 1);
    check("t4_trig_addr", trig_addr, 0);

    // Abort mid-POSTTRIG.
    push_range(0, 5);
    smpl_en = 1;
    repeat (5) step();
    smpl_en = 0; abort = 1;
    step(); abort = 0;
    check("t5_busy", busy, 0);
    check("t5_we", we, 0);
    check("t5_trig", triggered, 0);
    check("t5_done", capture_done, 0);
    smpl_en = 1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (capture_done || busy) cnt++;
    end
    check("t5_quiet", cnt, 0);
    check("t5_sb_empty", exp_q.size(), 0);

    // Restart after abort, with start ignored while ARMED (trig_pos not relatched).
    push_range(0, 5);
    push_range(5, 13);
    ch_en = 5'b00001; ch_trig = '0; trig_pos = 3; start = 1;
    step(); start = 0;
    check("t5_restart_waddr", waddr, 0);
    repeat (3) step();
    check("t6_armed", armed, 1);
    check("t6_armed_waddr", waddr, 3);
    start = 1; trig_pos = 7;
    step(); start = 0;
    check("t6_still_armed", armed, 1);
    check("t6_waddr_cont", waddr, 4);
    ch_trig = 5'b00001;
    step(); ch_trig = '0;
    check("t6_trig_addr", trig_addr, 5);
    wait_done("t6_done", 40);
    check("t6_done_waddr", waddr, 2);
    check("t6_sb_empty", exp_q.size(), 0);
    start = 1; clr_done = 1;
    step(); start = 0; clr_done = 0;
    check("t6_clr_wins_busy", busy, 0);
    check("t6_clr_wins_done", capture_done, 0);
    repeat (3) step();
    check("t6_no_new_capture", busy, 0);

    // Reset mid-ARMED.
    push_range(0, 3);
    trig_pos = 0; start = 1;
    step(); start = 0;
    step(); step();
    rst = 1;
    step(); rst = 0;
    check("t6_rst_armed", armed, 0);
    check("t6_rst_we", we, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_waddr", waddr, 0);
    check("t6_rst_taddr", trig_addr, 0);
    check("t6_rst_trig", triggered, 0);
    check("t6_rst_done", capture_done, 0);
    check("t6_sb_empty_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
